intt_cu: RTL and testbench
==========================

Name: intt_cu

Overview:
- Control unit for the inverse NTT datapath: 2048-point, 12 stages × 512 butterflies, Gentleman-Sande constant-geometry order.
- Sits beside the forward NTT control unit and drives the same ping-pong coefficient BRAM pair (left/right, 512 deep) and the inverse twiddle ROM.
- Reads sequentially, writes de-interleaved, and appends one n^-1 scaling pass.
- Generates read/write addresses, write enables, mux selects and a start/busy/done handshake.

Parameters:
- COE_WIDTH, 39, coefficient width; passed through for consistency, no logic depends on it.
- BRAM_DELAY, 2, read latency of BRAM/ROM in cycles (select alignment).
- PIP_DELAY, 12, issue-to-writeback latency of the butterfly datapath in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- intt_start  in  1  start request, sampled only in IDLE.
- coe_mux_sel  out  1  read-bank select: stage_d[BRAM_DELAY][0].
- tf_mux_sel  out  4  stage_d[BRAM_DELAY], values 0..12.
- swap_mux0_sel  out  1  bf_d[PIP_DELAY-1][0].
- scale_en  out  1  high when stage_d[BRAM_DELAY]==12; selects the n^-1 multiply path.
- o_we_a_l  out  1  write enable, left bank.
- o_we_a_r  out  1  write enable, right bank.
- o_addr_a_l, o_addr_a_r  out  9  write address, both banks, equal.
- o_addr_b_l, o_addr_b_r  out  9  read address, both banks, equal.
- o_addr_tf  out  11  inverse twiddle ROM address.
- intt_busy  out  1  operation in progress.
- intt_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, delay lines and valid bits cleared. Reset mid-operation aborts immediately with no further writes.
- FSM states:
  - IDLE: on intt_start go to ISSUE.
  - ISSUE: 13-bit cnt runs 0..6655, one value per cycle. stage=cnt[12:9] (0..11 butterfly stages, 12 = scale pass); bf=cnt[8:0]. At cnt==6655 go to DRAIN.
  - DRAIN: wait until the valid line is empty (PIP_DELAY cycles after the last issue), then pulse intt_done for 1 cycle and go to IDLE.
- intt_start is ignored outside IDLE. A start held high re-triggers only after returning to IDLE.
- intt_busy: high in ISSUE and DRAIN, low in IDLE. It is low on the done-pulse cycle.
- Read address: o_addr_b = bf, undelayed, in every ISSUE cycle. Outside ISSUE: 0.
- Delay lines: stage_d[i], bf_d[i] and valid_d[i] are i-cycle delays of (stage, bf, issuing), i = 0..PIP_DELAY.
- Write, driven from index PIP_DELAY and qualified by valid_d[PIP_DELAY]:
  - Stages 0..11: o_addr_a = {bf_d[0], bf_d[8:1]}.
  - Stage 12: o_addr_a = bf_d.
  - o_we_a_l = valid & stage_d[0]; o_we_a_r = valid & ~stage_d[0].
  - When not valid: both enables 0, address 0.
- Twiddle address, undelayed, with k = 11 − stage:
  - k=0 → 1.
  - k=1..9 → (1<<k) + bf[k-1:0].
  - k=10 → 1024 + bf.
  - k=11 → 1536 + bf.
  - stage 12 → 0 (n^-1 constant).
  - Outside ISSUE → 0.
- Total latency: start sampled at cycle T → first issue at T+1, last write at T+6668, intt_done at T+6669.

Decomposition:
- Shared package, the existing ntt_intt_defines header:
  - stage count 12, butterflies per stage 512, scale-stage index 12, last count 6655.
  - twiddle base offsets 1024 and 1536, n^-1 ROM address 0.
  - state encodings IDLE/ISSUE/DRAIN, one-hot.
- Sub-module intt_cu_delay: parameterised shift register carrying {valid, stage, bf}, exposing taps BRAM_DELAY, PIP_DELAY-1 and PIP_DELAY. Reset clears the valid bits.

Test Plan:
- Reset: assert rst mid-cycle, no clock → all outputs 0 immediately. Deassert, idle 20 cycles → no we pulses, intt_busy=0.
- Start pulse at T:
  - T+1: o_addr_b=0, o_addr_tf=1536.
  - T+2: o_addr_b=1, o_addr_tf=1537.
  - Stage 2 (k=9), first cycle: o_addr_tf=512.
- Writeback:
  - T+13: o_we_a_r=1, o_addr_a=0.
  - T+14: o_addr_a=256.
  - T+15: o_addr_a=1.
  - Stage 1 writes use o_we_a_l only.
- Scale pass: cnt 6144..6655 → o_addr_tf=0. scale_en high from T+6145+BRAM_DELAY. Writes are sequential 0..511 on the right bank.
- Completion: last we at T+6668, intt_done=1 only at T+6669, intt_busy low from T+6669. A start at T+100 has no effect.
- Abort: rst pulse at T+3000 → outputs 0, no writes after reset. A new start runs a full clean 6669-cycle sequence.

Source files
------------

// File: rtl/intt_cu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intt_cu_pkg
// Description : Shared definitions for the inverse-NTT control unit:
//               transform geometry, twiddle ROM offsets, FSM encodings,
//               the delay-line slot type and the twiddle address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package intt_cu_pkg;

    // Transform geometry: 12 butterfly stages plus one n^-1 scaling pass,
    // 512 butterflies each.
    localparam int          c_NUM_STAGES    = 12;
    localparam int          c_BF_PER_STAGE  = 512;
    localparam logic [3:0]  c_SCALE_STAGE   = 4'd12;
    localparam logic [12:0] c_LAST_CNT      =
        13'((c_NUM_STAGES + 1) * c_BF_PER_STAGE - 1);

    // Inverse twiddle ROM layout.
    localparam logic [10:0] c_TF_BASE_K10   = 11'd1024;
    localparam logic [10:0] c_TF_BASE_K11   = 11'd1536;
    localparam logic [10:0] c_TF_NINV_ADDR  = 11'd0;

    // One-hot FSM encodings.
    localparam logic [2:0]  c_ST_IDLE       = 3'b001;
    localparam logic [2:0]  c_ST_ISSUE      = 3'b010;
    localparam logic [2:0]  c_ST_DRAIN      = 3'b100;

    // One slot of the issue-to-writeback delay line.
    typedef struct packed {
        logic       valid;
        logic [3:0] stage;
        logic [8:0] bf;
    } intt_slot_t;

    // Twiddle ROM address for a butterfly, with k = 11 - stage.
    // Stage k reads the 2^k-entry table starting at 2^k; the two largest
    // tables (k = 10, 11) live at fixed offsets because 2^11 does not fit.
    function automatic logic [10:0] intt_tf_addr(input logic [3:0] stage,
                                                 input logic [8:0] bf);
        logic [3:0]  k;
        logic [10:0] base;
        logic [10:0] mask;
        k    = 4'd11 - stage;
        base = 11'd1 << k;
        mask = base - 11'd1;
        if (stage >= c_SCALE_STAGE) begin
            intt_tf_addr = c_TF_NINV_ADDR;
        end else if (k == 4'd11) begin
            intt_tf_addr = c_TF_BASE_K11 + {2'b00, bf};
        end else if (k == 4'd10) begin
            intt_tf_addr = c_TF_BASE_K10 + {2'b00, bf};
        end else if (k == 4'd0) begin
            intt_tf_addr = 11'd1;
        end else begin
            intt_tf_addr = base + ({2'b00, bf} & mask);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/intt_cu_delay.sv
`default_nettype none
// ============================================================================
// Module      : intt_cu_delay
// Description : Shift register carrying {valid, stage, bf} from the issue
//               point to writeback. Tap 0 is the undelayed input; tap i is
//               an i-cycle delay.
// Ports       : clk, rst         - clock, async active-high reset
//               i_slot           - tap 0 (current issue)
//               o_bram_stage     - stage at tap TAP_BRAM
//               o_pm1_bf0        - bf[0] at tap DEPTH-1
//               o_pip            - full slot at tap DEPTH
//               o_pending        - any valid bit set in taps 1..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module intt_cu_delay
    import intt_cu_pkg::*;
#(
    parameter int DEPTH    = 12,
    parameter int TAP_BRAM = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  intt_slot_t i_slot,
    output logic [3:0] o_bram_stage,
    output logic       o_pm1_bf0,
    output intt_slot_t o_pip,
    output logic       o_pending
);

    intt_slot_t w_line [0:DEPTH];
    intt_slot_t r_line [1:DEPTH];

    assign w_line[0] = i_slot;

    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_line[gi] <= '0;
            end else begin
                r_line[gi] <= w_line[gi-1];
            end
        end
        assign w_line[gi] = r_line[gi];
    end

    assign o_bram_stage = w_line[TAP_BRAM].stage;
    assign o_pm1_bf0    = w_line[DEPTH-1].bf[0];
    assign o_pip        = w_line[DEPTH];

    always_comb begin
        o_pending = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            o_pending = o_pending | w_line[i].valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/intt_cu.sv
`default_nettype none
// ============================================================================
// Module      : intt_cu
// Description : Control unit for the 2048-point inverse NTT (12 GS stages of
//               512 butterflies, constant geometry) plus one n^-1 scaling
//               pass. Reads sequentially, writes de-interleaved into the
//               ping-pong BRAM pair, addresses the inverse twiddle ROM.
// Ports       : clk, rst            - clock, async active-high reset
//               intt_start          - start request (sampled in IDLE only)
//               coe_mux_sel         - read-bank select (delayed stage[0])
//               tf_mux_sel          - delayed stage, 0..12
//               swap_mux0_sel       - delayed bf[0] for the output swap
//               scale_en            - n^-1 multiply path select
//               o_we_a_l/o_we_a_r   - bank write enables
//               o_addr_a_l/_r       - write address (both banks)
//               o_addr_b_l/_r       - read address (both banks)
//               o_addr_tf           - inverse twiddle ROM address
//               intt_busy/intt_done - handshake
// Revision    : 1.0 - initial release
// ============================================================================
module intt_cu
    import intt_cu_pkg::*;
#(
    parameter int COE_WIDTH  = 39,
    parameter int BRAM_DELAY = 2,
    parameter int PIP_DELAY  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        intt_start,
    output logic        coe_mux_sel,
    output logic [3:0]  tf_mux_sel,
    output logic        swap_mux0_sel,
    output logic        scale_en,
    output logic        o_we_a_l,
    output logic        o_we_a_r,
    output logic [8:0]  o_addr_a_l,
    output logic [8:0]  o_addr_a_r,
    output logic [8:0]  o_addr_b_l,
    output logic [8:0]  o_addr_b_r,
    output logic [10:0] o_addr_tf,
    output logic        intt_busy,
    output logic        intt_done
);

    // Coefficient width only matters to the datapath; guard against nonsense.
    if (COE_WIDTH < 1) begin : g_coe_width_check
        $error("intt_cu: COE_WIDTH must be positive");
    end

    logic [2:0]  r_state;
    logic [12:0] r_cnt;

    logic        w_issue;
    logic        w_drain;
    logic [3:0]  w_stage;
    logic [8:0]  w_bf;
    intt_slot_t  w_slot;
    intt_slot_t  w_pip;
    logic [3:0]  w_bram_stage;
    logic        w_pm1_bf0;
    logic        w_pending;
    logic [8:0]  w_addr_a;

    assign w_issue = (r_state == c_ST_ISSUE);
    assign w_drain = (r_state == c_ST_DRAIN);
    assign w_stage = r_cnt[12:9];
    assign w_bf    = r_cnt[8:0];

    // Idle slots enter the delay line as all-zero so taps read 0 when idle.
    always_comb begin
        w_slot = '0;
        if (w_issue) begin
            w_slot.valid = 1'b1;
            w_slot.stage = w_stage;
            w_slot.bf    = w_bf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (intt_start) begin
                        r_state <= c_ST_ISSUE;
                        r_cnt   <= '0;
                    end
                end
                c_ST_ISSUE: begin
                    if (r_cnt == c_LAST_CNT) begin
                        r_state <= c_ST_DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end
                c_ST_DRAIN: begin
                    if (!w_pending) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    intt_cu_delay #(
        .DEPTH    (PIP_DELAY),
        .TAP_BRAM (BRAM_DELAY)
    ) u_delay (
        .clk          (clk),
        .rst          (rst),
        .i_slot       (w_slot),
        .o_bram_stage (w_bram_stage),
        .o_pm1_bf0    (w_pm1_bf0),
        .o_pip        (w_pip),
        .o_pending    (w_pending)
    );

    // Selects aligned with the BRAM/ROM read data.
    assign coe_mux_sel   = w_bram_stage[0];
    assign tf_mux_sel    = w_bram_stage;
    assign scale_en      = (w_bram_stage == c_SCALE_STAGE);
    assign swap_mux0_sel = w_pm1_bf0;

    // Read side: sequential within a stage.
    assign o_addr_b_l = w_issue ? w_bf : 9'd0;
    assign o_addr_b_r = w_issue ? w_bf : 9'd0;
    assign o_addr_tf  = w_issue ? intt_tf_addr(w_stage, w_bf) : 11'd0;

    // Write side: butterfly stages de-interleave (rotate bf right by one so
    // even/odd outputs land in the lower/upper half); the scale pass writes
    // in place. Odd stages go to the left bank, even stages to the right.
    always_comb begin
        w_addr_a = 9'd0;
        o_we_a_l = 1'b0;
        o_we_a_r = 1'b0;
        if (w_pip.valid) begin
            if (w_pip.stage == c_SCALE_STAGE) begin
                w_addr_a = w_pip.bf;
            end else begin
                w_addr_a = {w_pip.bf[0], w_pip.bf[8:1]};
            end
            o_we_a_l = w_pip.stage[0];
            o_we_a_r = ~w_pip.stage[0];
        end
    end

    assign o_addr_a_l = w_addr_a;
    assign o_addr_a_r = w_addr_a;

    // Done fires in the first DRAIN cycle with an empty pipeline; busy drops
    // in that same cycle.
    assign intt_done = w_drain & ~w_pending;
    assign intt_busy = w_issue | (w_drain & w_pending);

endmodule
`default_nettype wire

// File: tb/tb_intt_cu.sv
`default_nettype none
// ============================================================================
// Module      : tb_intt_cu
// Description : Directed self-checking bench for intt_cu. Cycle numbers are
//               counted from the start-sampling edge T; outputs are sampled
//               1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intt_cu;

    logic        clk = 1'b0;
    logic        rst;
    logic        intt_start;
    logic        coe_mux_sel;
    logic [3:0]  tf_mux_sel;
    logic        swap_mux0_sel;
    logic        scale_en;
    logic        o_we_a_l;
    logic        o_we_a_r;
    logic [8:0]  o_addr_a_l;
    logic [8:0]  o_addr_a_r;
    logic [8:0]  o_addr_b_l;
    logic [8:0]  o_addr_b_r;
    logic [10:0] o_addr_tf;
    logic        intt_busy;
    logic        intt_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [57:0] all_outs;
    assign all_outs = {coe_mux_sel, tf_mux_sel, swap_mux0_sel, scale_en,
                       o_we_a_l, o_we_a_r, o_addr_a_l, o_addr_a_r,
                       o_addr_b_l, o_addr_b_r, o_addr_tf, intt_busy, intt_done};

    intt_cu #(
        .COE_WIDTH  (39),
        .BRAM_DELAY (2),
        .PIP_DELAY  (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .intt_start    (intt_start),
        .coe_mux_sel   (coe_mux_sel),
        .tf_mux_sel    (tf_mux_sel),
        .swap_mux0_sel (swap_mux0_sel),
        .scale_en      (scale_en),
        .o_we_a_l      (o_we_a_l),
        .o_we_a_r      (o_we_a_r),
        .o_addr_a_l    (o_addr_a_l),
        .o_addr_a_r    (o_addr_a_r),
        .o_addr_b_l    (o_addr_b_l),
        .o_addr_b_r    (o_addr_b_r),
        .o_addr_tf     (o_addr_tf),
        .intt_busy     (intt_busy),
        .intt_done     (intt_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic goto(input int n);
        if (n > cyc) step(n - cyc);
    endtask

    initial begin
        rst        = 1'b0;
        intt_start = 1'b0;

        // Asynchronous reset with no clock edge yet.
        #2 rst = 1'b1;
        #1 chk("reset_async_outs", 64'(all_outs), 64'd0);
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_quiet", {o_we_a_l, o_we_a_r, intt_busy, intt_done}, 0);
        end

        // ---------------- Run 1: full operation ----------------
        intt_start = 1'b1;
        cyc = 0;
        step(1);
        intt_start = 1'b0;
        chk("t1_addr_b", o_addr_b_l, 0);
        chk("t1_addr_tf", o_addr_tf, 1536);
        chk("t1_busy", intt_busy, 1);
        goto(2);
        chk("t2_addr_b", o_addr_b_r, 1);
        chk("t2_addr_tf", o_addr_tf, 1537);
        goto(13);
        chk("t13_we", {o_we_a_l, o_we_a_r}, 2'b01);
        chk("t13_addr_a", {o_addr_a_l, o_addr_a_r}, 0);
        chk("t13_swap", swap_mux0_sel, 1);
        goto(14);
        chk("t14_addr_a", o_addr_a_l, 256);
        chk("t14_swap", swap_mux0_sel, 0);
        goto(15);
        chk("t15_addr_a", o_addr_a_r, 1);

        // Start while busy must be ignored.
        goto(99);
        intt_start = 1'b1;
        step(1);
        intt_start = 1'b0;
        chk("t100_addr_b", o_addr_b_l, 99);
        chk("t100_busy", intt_busy, 1);
        goto(101);
        chk("t101_addr_b", o_addr_b_l, 100);

        goto(513);
        chk("stage1_tf", o_addr_tf, 1024);
        chk("stage1_addr_b", o_addr_b_l, 0);
        goto(514);
        chk("t514_coe_sel", coe_mux_sel, 0);
        goto(515);
        chk("t515_coe_sel", coe_mux_sel, 1);
        chk("t515_tf_sel", tf_mux_sel, 1);
        goto(525);
        chk("stage1_we", {o_we_a_l, o_we_a_r}, 2'b10);
        chk("stage1_addr_a", o_addr_a_l, 0);
        goto(526);
        chk("stage1_addr_a1", o_addr_a_l, 256);
        goto(1025);
        chk("stage2_tf", o_addr_tf, 512);
        goto(1026);
        chk("stage2_tf1", o_addr_tf, 513);
        goto(2349);
        chk("stage4_tf", o_addr_tf, 172);
        goto(5121);
        chk("stage10_tf0", o_addr_tf, 2);
        goto(5122);
        chk("stage10_tf1", o_addr_tf, 3);
        goto(5123);
        chk("stage10_tf2", o_addr_tf, 2);
        goto(5633);
        chk("stage11_tf0", o_addr_tf, 1);
        goto(5700);
        chk("stage11_tf", o_addr_tf, 1);

        // Scale pass.
        goto(6145);
        chk("scale_tf", o_addr_tf, 0);
        chk("scale_addr_b", o_addr_b_l, 0);
        goto(6146);
        chk("t6146_scale_en", scale_en, 0);
        goto(6147);
        chk("t6147_scale_en", scale_en, 1);
        chk("t6147_tf_sel", tf_mux_sel, 12);
        goto(6156);
        chk("last_bf_we", {o_we_a_l, o_we_a_r}, 2'b10);
        chk("last_bf_addr_a", o_addr_a_l, 511);
        goto(6157);
        chk("scale_we", {o_we_a_l, o_we_a_r}, 2'b01);
        chk("scale_addr_a0", o_addr_a_r, 0);
        goto(6158);
        chk("scale_addr_a1", o_addr_a_r, 1);
        goto(6159);
        chk("scale_addr_a2", o_addr_a_r, 2);
        goto(6656);
        chk("last_issue_addr_b", o_addr_b_l, 511);
        chk("last_issue_busy", intt_busy, 1);
        goto(6657);
        chk("drain_addr_b", o_addr_b_l, 0);
        chk("drain_busy", intt_busy, 1);
        goto(6668);
        chk("last_we", {o_we_a_l, o_we_a_r}, 2'b01);
        chk("last_addr_a", o_addr_a_r, 511);
        chk("last_we_busy_done", {intt_busy, intt_done}, 2'b10);
        goto(6669);
        chk("done_cycle", {intt_busy, intt_done, o_we_a_l, o_we_a_r}, 4'b0100);
        goto(6670);
        chk("after_done", {intt_busy, intt_done}, 2'b00);

        // ---------------- Run 2: abort by reset ----------------
        intt_start = 1'b1;
        cyc = 0;
        step(1);
        intt_start = 1'b0;
        chk("run2_t1_tf", o_addr_tf, 1536);
        goto(3000);
        chk("run2_t3000_addr_b", o_addr_b_l, 439);
        chk("run2_t3000_busy", intt_busy, 1);
        #3 rst = 1'b1;
        #1 chk("abort_outs", 64'(all_outs), 64'd0);
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("post_abort_quiet", {o_we_a_l, o_we_a_r, intt_busy, intt_done}, 0);
        end

        // ---------------- Run 3: clean run with start held ----------------
        intt_start = 1'b1;
        cyc = 0;
        step(1);
        chk("run3_t1", {o_addr_b_l, o_addr_tf, intt_busy}, {9'd0, 11'd1536, 1'b1});
        goto(2);
        chk("run3_t2_addr_b", o_addr_b_l, 1);
        goto(13);
        chk("run3_t13", {o_we_a_r, o_addr_a_r}, {1'b1, 9'd0});
        goto(6668);
        chk("run3_last_we", {o_we_a_r, o_addr_a_r, intt_busy}, {1'b1, 9'd511, 1'b1});
        goto(6669);
        chk("run3_done", {intt_busy, intt_done}, 2'b01);
        goto(6670);
        chk("run3_idle", {intt_busy, intt_done, o_addr_b_l}, 0);
        goto(6671);
        chk("run3_retrigger", {intt_busy, o_addr_tf}, {1'b1, 11'd1536});
        intt_start = 1'b0;

        rst = 1'b1;
        step(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
